// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch parameter sweep sequencer.
//   - sweep_state_t : sequencer FSM states
//   - GLITCH_W      : default width of offset/duration values
//   - DEFAULT_*     : default fire/release timeout and settle time in cycles
//   - AX_DUR/AX_OFF : index of the duration / offset axis in the stepper array
package glitch_pkg;

    localparam int GLITCH_W               = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 24000000;
    localparam int DEFAULT_SETTLE_CYCLES  = 1000;

    localparam int AX_DUR = 0;
    localparam int AX_OFF = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_FIRE = 3'd2,
        ST_WAIT_REL  = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_ADVANCE   = 3'd5,
        ST_DONE      = 3'd6
    } sweep_state_t;

endpackage

// File: rtl/sweep_axis_step.sv
// One axis of the sweep: computes the next value along a range and reports
// whether the axis wraps back to its start value.
// Ports:
//   value      in  W  current point on this axis
//   step       in  W  increment
//   start_val  in  W  first value of the range (returned on wrap)
//   end_val    in  W  last value of the range (inclusive)
//   next_value out W  value + step, or start_val when wrapping
//   wrap       out 1  zero step, carry out of W bits, or past end_val
module sweep_axis_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic [W-1:0] start_val,
    input  logic [W-1:0] end_val,
    output logic [W-1:0] next_value,
    output logic         wrap
);

    logic [W:0] sum;

    // The extra MSB catches overflow so a range ending near all-ones
    // terminates instead of wrapping around to small values.
    always_comb begin
        sum        = {1'b0, value} + {1'b0, step};
        wrap       = (step == '0) || sum[W] || (sum[W-1:0] > end_val);
        next_value = wrap ? start_val : sum[W-1:0];
    end

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Glitch parameter sweep sequencer. Walks offset (outer loop) and duration
// (inner loop) over host-supplied inclusive ranges, repeating each point
// cfg_repeats times. Each attempt pulses target_reset, waits for a complete
// glitch_active pulse, then for tx_release, settles, and advances.
//
// Optional build macro: GLITCH_SWEEP_STOP_ON_HIT_EN
//   adds input hit and outputs hit_offset/hit_duration/hit_valid; a hit seen
//   while waiting for release or settling records the point and ends the sweep.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle pulse: latch cfg_* and begin (IDLE only)
//   abort                 level: return to IDLE, counters hold, no done
//   cfg_off_* / cfg_dur_* offset / duration ranges (start, end, step)
//   cfg_repeats           attempts per point (0 behaves as 1)
//   glitch_active         glitch pulse level from the power controller
//   tx_release            target UART released
//   glitch_offset/_duration current point
//   target_reset          one-cycle reset request per attempt
//   busy                  sweep in progress
//   done                  one-cycle pulse at completion or on config error
//   cfg_err               invalid range at last start (sticky)
//   attempt_count         attempts since start (saturating)
//   timeout_count         timed-out attempts (saturating)
module glitch_sweep_sequencer
    import glitch_pkg::*;
#(
    parameter int W              = GLITCH_W,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int SETTLE_CYCLES  = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     cfg_off_start,
    input  logic [W-1:0]     cfg_off_end,
    input  logic [W-1:0]     cfg_off_step,
    input  logic [W-1:0]     cfg_dur_start,
    input  logic [W-1:0]     cfg_dur_end,
    input  logic [W-1:0]     cfg_dur_step,
    input  logic [CNT_W-1:0] cfg_repeats,
    input  logic             glitch_active,
    input  logic             tx_release,
    output logic [W-1:0]     glitch_offset,
    output logic [W-1:0]     glitch_duration,
    output logic             target_reset,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] attempt_count,
    output logic [CNT_W-1:0] timeout_count
`ifdef GLITCH_SWEEP_STOP_ON_HIT_EN
    ,
    input  logic             hit,
    output logic [W-1:0]     hit_offset,
    output logic [W-1:0]     hit_duration,
    output logic             hit_valid
`endif
);

    localparam int          TMR_W       = 32;
    localparam [TMR_W-1:0]  TMO_LOAD    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    sweep_state_t state_reg, state_next;

    logic [W-1:0]     off_reg, dur_reg;
    logic [W-1:0]     off_start_reg, off_end_reg, off_step_reg;
    logic [W-1:0]     dur_start_reg, dur_end_reg, dur_step_reg;
    logic [CNT_W-1:0] rep_eff_reg, rep_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [CNT_W-1:0] attempt_reg, timeout_reg;
    logic             cfg_err_reg;
    logic             err_done_reg;
    logic             ga_q_reg;
    logic             seen_rise_reg;

    // Axis steppers: index AX_DUR is the inner loop, AX_OFF the outer loop.
    logic [W-1:0] ax_val   [2];
    logic [W-1:0] ax_step  [2];
    logic [W-1:0] ax_start [2];
    logic [W-1:0] ax_end   [2];
    logic [W-1:0] ax_next  [2];
    logic         ax_wrap  [2];

    assign ax_val[AX_DUR]   = dur_reg;
    assign ax_step[AX_DUR]  = dur_step_reg;
    assign ax_start[AX_DUR] = dur_start_reg;
    assign ax_end[AX_DUR]   = dur_end_reg;
    assign ax_val[AX_OFF]   = off_reg;
    assign ax_step[AX_OFF]  = off_step_reg;
    assign ax_start[AX_OFF] = off_start_reg;
    assign ax_end[AX_OFF]   = off_end_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            sweep_axis_step #(.W(W)) u_step (
                .value      (ax_val[gi]),
                .step       (ax_step[gi]),
                .start_val  (ax_start[gi]),
                .end_val    (ax_end[gi]),
                .next_value (ax_next[gi]),
                .wrap       (ax_wrap[gi])
            );
        end
    endgenerate

    logic             cfg_ok;
    logic             ga_rise, ga_fall, fire;
    logic             timer_zero;
    logic [CNT_W-1:0] rep_inc;
    logic             rep_more;
    logic             hit_take;

    assign cfg_ok     = (cfg_off_start <= cfg_off_end) && (cfg_dur_start <= cfg_dur_end);
    assign ga_rise    = glitch_active & ~ga_q_reg;
    assign ga_fall    = ~glitch_active & ga_q_reg;
    // Only a complete pulse counts: a fall that follows a rise seen after ARM.
    assign fire       = ga_fall & seen_rise_reg;
    assign timer_zero = (timer_reg == '0);
    assign rep_inc    = rep_reg + CNT_W'(1);
    assign rep_more   = (rep_inc < rep_eff_reg);

`ifdef GLITCH_SWEEP_STOP_ON_HIT_EN
    assign hit_take = hit && ((state_reg == ST_WAIT_REL) || (state_reg == ST_SETTLE));
`else
    assign hit_take = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (start) state_next = cfg_ok ? ST_ARM : ST_IDLE;
            ST_ARM:       state_next = ST_WAIT_FIRE;
            ST_WAIT_FIRE: begin
                if (fire)            state_next = ST_WAIT_REL;
                else if (timer_zero) state_next = ST_SETTLE;
            end
            ST_WAIT_REL:  if (tx_release || timer_zero) state_next = ST_SETTLE;
            ST_SETTLE:    if (timer_zero) state_next = ST_ADVANCE;
            ST_ADVANCE: begin
                if (rep_more || !ax_wrap[AX_DUR] || !ax_wrap[AX_OFF])
                    state_next = ST_ARM;
                else
                    state_next = ST_DONE;
            end
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
        if (hit_take) state_next = ST_DONE;
        if (abort)    state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            off_reg       <= '0;
            dur_reg       <= '0;
            off_start_reg <= '0;
            off_end_reg   <= '0;
            off_step_reg  <= '0;
            dur_start_reg <= '0;
            dur_end_reg   <= '0;
            dur_step_reg  <= '0;
            rep_eff_reg   <= '0;
            rep_reg       <= '0;
            timer_reg     <= '0;
            attempt_reg   <= '0;
            timeout_reg   <= '0;
            cfg_err_reg   <= 1'b0;
            err_done_reg  <= 1'b0;
            ga_q_reg      <= 1'b0;
            seen_rise_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ga_q_reg     <= glitch_active;
            err_done_reg <= 1'b0;
            if (!abort && !hit_take) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            off_start_reg <= cfg_off_start;
                            off_end_reg   <= cfg_off_end;
                            off_step_reg  <= cfg_off_step;
                            dur_start_reg <= cfg_dur_start;
                            dur_end_reg   <= cfg_dur_end;
                            dur_step_reg  <= cfg_dur_step;
                            rep_eff_reg   <= (cfg_repeats == '0) ? CNT_W'(1) : cfg_repeats;
                            if (cfg_ok) begin
                                off_reg     <= cfg_off_start;
                                dur_reg     <= cfg_dur_start;
                                rep_reg     <= '0;
                                attempt_reg <= '0;
                                timeout_reg <= '0;
                                cfg_err_reg <= 1'b0;
                            end else begin
                                cfg_err_reg  <= 1'b1;
                                err_done_reg <= 1'b1;
                            end
                        end
                    end
                    ST_ARM: begin
                        if (attempt_reg != '1) attempt_reg <= attempt_reg + CNT_W'(1);
                        timer_reg     <= TMO_LOAD;
                        seen_rise_reg <= 1'b0;
                    end
                    ST_WAIT_FIRE: begin
                        if (ga_rise) seen_rise_reg <= 1'b1;
                        if (fire) begin
                            timer_reg <= TMO_LOAD;
                        end else if (timer_zero) begin
                            if (timeout_reg != '1) timeout_reg <= timeout_reg + CNT_W'(1);
                            timer_reg <= SETTLE_LOAD;
                        end else begin
                            timer_reg <= timer_reg - TMR_W'(1);
                        end
                    end
                    ST_WAIT_REL: begin
                        if (tx_release) begin
                            timer_reg <= SETTLE_LOAD;
                        end else if (timer_zero) begin
                            if (timeout_reg != '1) timeout_reg <= timeout_reg + CNT_W'(1);
                            timer_reg <= SETTLE_LOAD;
                        end else begin
                            timer_reg <= timer_reg - TMR_W'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (!timer_zero) timer_reg <= timer_reg - TMR_W'(1);
                    end
                    ST_ADVANCE: begin
                        if (rep_more) begin
                            rep_reg <= rep_inc;
                        end else begin
                            rep_reg <= '0;
                            // On final wrap the last point is kept on the outputs.
                            if (!ax_wrap[AX_DUR]) begin
                                dur_reg <= ax_next[AX_DUR];
                            end else if (!ax_wrap[AX_OFF]) begin
                                dur_reg <= dur_start_reg;
                                off_reg <= ax_next[AX_OFF];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef GLITCH_SWEEP_STOP_ON_HIT_EN
    logic [W-1:0] hit_off_reg, hit_dur_reg;
    logic         hit_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_off_reg   <= '0;
            hit_dur_reg   <= '0;
            hit_valid_reg <= 1'b0;
        end else if (!abort) begin
            if (hit_take) begin
                hit_off_reg   <= off_reg;
                hit_dur_reg   <= dur_reg;
                hit_valid_reg <= 1'b1;
            end else if (state_reg == ST_IDLE && start) begin
                hit_valid_reg <= 1'b0;
            end
        end
    end

    assign hit_offset   = hit_off_reg;
    assign hit_duration = hit_dur_reg;
    assign hit_valid    = hit_valid_reg;
`endif

    assign glitch_offset   = off_reg;
    assign glitch_duration = dur_reg;
    assign target_reset    = (state_reg == ST_ARM) && !abort;
    assign busy            = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done            = (state_reg == ST_DONE) || err_done_reg;
    assign cfg_err         = cfg_err_reg;
    assign attempt_count   = attempt_reg;
    assign timeout_count   = timeout_reg;

endmodule
